// File: rtl/div_sequencer.sv
// Sequencer between M-extension issue and the multi-cycle divider: holds operands, pulses start, returns result.
// Optional one-entry result cache enabled by defining DIV_SEQ_RESULT_CACHE_EN; width defaults to 32.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic            div_start,
  output logic [1:0]      div_op,
  output logic            div_word,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_result,
  input  logic            div_busy,
  input  logic            div_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [1:0]      r_op;
  logic            r_word;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_resp_data;
  logic            w_accept;
  logic            w_word_in;
  logic            w_capture;
  logic            w_hit;
  logic            w_unused_div_busy;

  assign w_unused_div_busy = div_busy;
  assign w_accept  = req_valid & (r_state == S_IDLE) & ~flush;
  assign w_word_in = (XLEN == 64) ? req_word : 1'b0;
  assign w_capture = (r_state == S_WAIT) & div_ready & ~flush;

`ifdef DIV_SEQ_RESULT_CACHE_EN
  logic            r_c_valid;
  logic [1:0]      r_c_op;
  logic            r_c_word;
  logic [XLEN-1:0] r_c_a;
  logic [XLEN-1:0] r_c_b;
  logic [XLEN-1:0] r_c_res;

  assign w_hit = r_c_valid & (r_c_op == req_op) & (r_c_word == w_word_in) &
                 (r_c_a == req_a) & (r_c_b == req_b);

  // Cache holds the last captured result; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c_valid <= 1'b0;
      r_c_op    <= 2'b00;
      r_c_word  <= 1'b0;
      r_c_a     <= {XLEN{1'b0}};
      r_c_b     <= {XLEN{1'b0}};
      r_c_res   <= {XLEN{1'b0}};
    end else if (w_capture) begin
      r_c_valid <= 1'b1;
      r_c_op    <= r_op;
      r_c_word  <= r_word;
      r_c_a     <= r_a;
      r_c_b     <= r_b;
      r_c_res   <= div_result;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Next-state selection; the divider cannot abort, so a flush mid-operation drains.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_hit ? S_RESP : S_START;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_START: begin
        w_next = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (div_ready) begin
          w_next = flush ? S_IDLE : S_RESP;
        end else if (flush) begin
          w_next = S_DRAIN;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      S_DRAIN: begin
        w_next = div_ready ? S_IDLE : S_DRAIN;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State, operand latches and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_word      <= 1'b0;
      r_a         <= {XLEN{1'b0}};
      r_b         <= {XLEN{1'b0}};
      r_resp_data <= {XLEN{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= req_op;
        r_word <= w_word_in;
        r_a    <= req_a;
        r_b    <= req_b;
      end
      if (w_capture) begin
        r_resp_data <= div_result;
      end else if (w_accept && w_hit) begin
`ifdef DIV_SEQ_RESULT_CACHE_EN
        r_resp_data <= r_c_res;
`else
        r_resp_data <= r_resp_data;
`endif
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign div_start    = (r_state == S_START);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_data    = r_resp_data;
  assign div_op       = r_op;
  assign div_word     = r_word;
  assign div_dividend = r_a;
  assign div_divisor  = r_b;

endmodule
